rgb_led_pwm: RTL

Parametrised multi-channel RGB LED PWM controller with an Avalon-MM register slave. It replaces the plain on/off PIO exports that drive the board's RGB LEDs with per-colour brightness control. It supports NUM_LEDS RGB LEDs with glitch-free, period-aligned duty updates and an optional hardware fade engine. It sits inside the Platform Designer system on the 25 MHz system clock, and its `led_out` bus is split onto the LEDxR/G/B pins in the top level.

---
 rtl/rgb_led_pwm_pkg.sv | 46 ++++
 rtl/rgb_pwm_channel.sv | 68 ++++++
 rtl/rgb_led_pwm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rgb_led_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_pwm_pkg
// Desc     : Shared constants for the RGB LED PWM controller: register map
//            offsets, colour field positions, CTRL bit indices, colour ids.
// Revision : 1.0 - initial release
// ============================================================================
package rgb_led_pwm_pkg;

    // Colour index within one LED; also the channel offset inside an LED triplet
    typedef enum logic [1:0] {
        COLOUR_B = 2'd0,
        COLOUR_G = 2'd1,
        COLOUR_R = 2'd2
    } colour_e;

    localparam int c_NUM_COLOURS      = 3;

    // Register map: colour words start at 0, CTRL follows the last LED
    localparam int c_COLOUR_BASE_ADDR = 0;

    // Colour field LSB positions in a colour register word
    localparam int c_FIELD_LSB_R      = 16;
    localparam int c_FIELD_LSB_G      = 8;
    localparam int c_FIELD_LSB_B      = 0;

    // CTRL register bits
    localparam int c_CTRL_ENABLE_BIT  = 0;
    localparam int c_CTRL_RESTART_BIT = 1;

    // Bit position of a colour's field inside a colour register word
    function automatic int field_lsb(input int colour);
        case (colour)
            int'(COLOUR_R): return c_FIELD_LSB_R;
            int'(COLOUR_G): return c_FIELD_LSB_G;
            default:        return c_FIELD_LSB_B;
        endcase
    endfunction

    // Word address of the CTRL register for a given LED count
    function automatic int ctrl_addr(input int num_leds);
        return c_COLOUR_BASE_ADDR + num_leds;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_channel
// Desc     : One PWM colour channel. Holds the active duty (loaded or faded
//            toward the target only at period boundaries) and produces a
//            registered compare output.
// Config   : RGB_PWM_FADE_EN selects ramped duty updates.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_channel #(
    parameter int PWM_BITS       = 8,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [PWM_BITS-1:0] i_cnt,
    input  logic                i_wrap,
    input  logic                i_fade_step,
    input  logic [PWM_BITS-1:0] i_target,
    output logic                o_led
);

    localparam logic c_IDLE_LEVEL = (LED_ACTIVE_LOW != 0);

    logic [PWM_BITS-1:0] r_duty;
    logic                r_led;

`ifdef RGB_PWM_FADE_EN
    // Move the active duty one LSB toward the target on each fade step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else if (i_wrap && i_fade_step) begin
            if (r_duty < i_target) begin
                r_duty <= r_duty + 1'b1;
            end else if (r_duty > i_target) begin
                r_duty <= r_duty - 1'b1;
            end
        end
    end
`else
    logic w_unused_fade;
    assign w_unused_fade = i_fade_step;

    // Latch the target only at the period boundary so a period is never split
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else if (i_wrap) begin
            r_duty <= i_target;
        end
    end
`endif

    // Registered compare; forced to the idle level while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= c_IDLE_LEVEL;
        end else begin
            r_led <= (i_enable && (i_cnt < r_duty)) ^ c_IDLE_LEVEL;
        end
    end

    assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/rgb_led_pwm.sv
`default_nettype none
// ============================================================================
// Module   : rgb_led_pwm
// Desc     : Multi-channel RGB LED PWM controller with an Avalon-MM register
//            slave. Holds the register file, address decode, prescaler, the
//            PWM tick counter and (optionally) the fade-period counter.
// Config   : define RGB_PWM_FADE_EN to build the hardware fade engine.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_led_pwm
    import rgb_led_pwm_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int PWM_BITS       = 8,
    parameter int PRESCALE       = 98,
    parameter int FADE_PERIODS   = 4,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic                              sys_clk,
    input  logic                              sys_reset,
    input  logic [$clog2(NUM_LEDS+1)-1:0]     avs_address,
    input  logic                              avs_write,
    input  logic [31:0]                       avs_writedata,
    input  logic                              avs_read,
    output logic [31:0]                       avs_readdata,
    output logic [3*NUM_LEDS-1:0]             led_out
);

    localparam int c_NUM_CH = c_NUM_COLOURS * NUM_LEDS;
    localparam int c_ADDR_W = $clog2(NUM_LEDS + 1);
    localparam int c_PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_ADDR_W-1:0] c_CTRL_ADDR = c_ADDR_W'(ctrl_addr(NUM_LEDS));
    localparam logic [PWM_BITS-1:0] c_CNT_LAST  = '1;

    logic [PWM_BITS-1:0] r_target [c_NUM_CH];
    logic                r_enable;
    logic [c_PRE_W-1:0]  r_pre;
    logic [PWM_BITS-1:0] r_cnt;
    logic [31:0]         r_readdata;

    logic [31:0]         w_rd_mux;
    logic                w_wr_ctrl;
    logic                w_restart;
    logic                w_tick;
    logic                w_wrap;
    logic                w_fade_step;
    logic [c_NUM_CH-1:0] w_led;
    logic                w_unused_wdata;

    // Not every write-data bit is stored (upper byte, bits above PWM_BITS)
    assign w_unused_wdata = ^avs_writedata;

    assign w_wr_ctrl = avs_write && (avs_address == c_CTRL_ADDR);
    assign w_restart = w_wr_ctrl && avs_writedata[c_CTRL_RESTART_BIT];
    // A restart write overrides a tick landing on the same cycle
    assign w_tick    = r_enable && !w_restart && (r_pre == c_PRE_LAST);
    assign w_wrap    = w_tick && (r_cnt == c_CNT_LAST);

    // Register file: colour targets and the enable bit
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_enable <= 1'b0;
            for (int ch = 0; ch < c_NUM_CH; ch++) begin
                r_target[ch] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= avs_writedata[c_CTRL_ENABLE_BIT];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (avs_write && (avs_address == c_ADDR_W'(c_COLOUR_BASE_ADDR + i))) begin
                    for (int c = 0; c < c_NUM_COLOURS; c++) begin
                        r_target[c_NUM_COLOURS*i + c] <= avs_writedata[field_lsb(c) +: PWM_BITS];
                    end
                end
            end
        end
    end

    // Read mux: stored targets zero-extended, CTRL returns enable only
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (avs_address == c_ADDR_W'(c_COLOUR_BASE_ADDR + i)) begin
                for (int c = 0; c < c_NUM_COLOURS; c++) begin
                    w_rd_mux[field_lsb(c) +: PWM_BITS] = r_target[c_NUM_COLOURS*i + c];
                end
            end
        end
        if (avs_address == c_CTRL_ADDR) begin
            w_rd_mux[c_CTRL_ENABLE_BIT] = r_enable;
        end
    end

    // Read data captured on a read strobe and held until the next read
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rd_mux;
        end
    end

    // Prescaler and PWM tick counter; both parked at 0 while disabled
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (!r_enable || w_restart) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

`ifdef RGB_PWM_FADE_EN
    localparam int c_FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [c_FADE_W-1:0] c_FADE_LAST = c_FADE_W'(FADE_PERIODS - 1);

    logic [c_FADE_W-1:0] r_fade_cnt;

    // Count wraps so the duties ramp once every FADE_PERIODS periods
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_fade_cnt <= '0;
        end else if (w_wrap) begin
            if (r_fade_cnt == c_FADE_LAST) begin
                r_fade_cnt <= '0;
            end else begin
                r_fade_cnt <= r_fade_cnt + 1'b1;
            end
        end
    end

    assign w_fade_step = w_wrap && (r_fade_cnt == c_FADE_LAST);
`else
    assign w_fade_step = 1'b0;
`endif

    for (genvar ch = 0; ch < c_NUM_CH; ch++) begin : g_channel
        rgb_pwm_channel #(
            .PWM_BITS       (PWM_BITS),
            .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
        ) u_channel (
            .clk         (sys_clk),
            .rst         (sys_reset),
            .i_enable    (r_enable),
            .i_cnt       (r_cnt),
            .i_wrap      (w_wrap),
            .i_fade_step (w_fade_step),
            .i_target    (r_target[ch]),
            .o_led       (w_led[ch])
        );
    end

    assign led_out      = w_led;
    assign avs_readdata = r_readdata;

endmodule
`default_nettype wire
